// File: rtl/quan_bias_add_ctrl.sv
// rtl/quan_bias_add_ctrl.sv - bias fetch and bias-add enable sequencer for one quantised layer pass
module quan_bias_add_ctrl #(
    parameter int bias_width      = 8,
    parameter int bias_set_width  = 16,
    parameter int bias_addr_width = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [3:0]                 mode,
    input  logic [9:0]                 cfg_ch_groups,
    input  logic [7:0]                 cfg_tiles,
    input  logic [bias_addr_width-1:0] cfg_bias_base,
    output logic                       bias_rd_en,
    output logic [bias_addr_width-1:0] bias_rd_addr,
    input  logic [bias_set_width-1:0]  bias_rd_data,
    input  logic                       sum_valid,
    output logic                       sum_ready,
    output logic [bias_set_width-1:0]  next_bias_set,
    output logic                       core_product_add_bias_en_pre,
    output logic                       busy,
    output logic                       done,
    output logic                       cfg_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t                     state;
    logic                       mode_q;
    logic [9:0]                 groups_q;
    logic [7:0]                 tiles_q;
    logic [bias_addr_width-1:0] base_q;
    logic [9:0]                 group_cnt;
    logic [7:0]                 tile_cnt;

    // Vectors are only accepted while a bias set is loaded and stable.
    assign sum_ready = (state == RUN);

    // Pass sequencer: config latch, per-group bias fetch, tile counting and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                        <= IDLE;
            mode_q                       <= 1'b0;
            groups_q                     <= '0;
            tiles_q                      <= '0;
            base_q                       <= '0;
            group_cnt                    <= '0;
            tile_cnt                     <= '0;
            bias_rd_en                   <= 1'b0;
            bias_rd_addr                 <= '0;
            next_bias_set                <= '0;
            core_product_add_bias_en_pre <= 1'b0;
            busy                         <= 1'b0;
            done                         <= 1'b0;
            cfg_err                      <= 1'b0;
        end else begin
            bias_rd_en                   <= 1'b0;
            core_product_add_bias_en_pre <= 1'b0;
            done                         <= 1'b0;
            cfg_err                      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (mode > 4'd1) begin
                            cfg_err <= 1'b1;
                        end else if (cfg_ch_groups == '0 || cfg_tiles == '0) begin
                            // Empty pass: report completion without touching the bias buffer.
                            state <= FIN;
                            busy  <= 1'b1;
                        end else begin
                            mode_q       <= mode[0];
                            groups_q     <= cfg_ch_groups;
                            tiles_q      <= cfg_tiles;
                            base_q       <= cfg_bias_base;
                            group_cnt    <= '0;
                            tile_cnt     <= '0;
                            bias_rd_en   <= 1'b1;
                            bias_rd_addr <= cfg_bias_base;
                            state        <= FETCH;
                            busy         <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    // Read data arrives here, one cycle after the strobe.
                    if (mode_q) begin
                        next_bias_set <= bias_rd_data;
                    end else begin
                        next_bias_set <= {{(bias_set_width-bias_width){1'b0}},
                                          bias_rd_data[bias_width-1:0]};
                    end
                    state <= RUN;
                end
                RUN: begin
                    if (sum_valid) begin
                        core_product_add_bias_en_pre <= 1'b1;
                        if (tile_cnt == tiles_q - 8'd1) begin
                            if (group_cnt == groups_q - 10'd1) begin
                                state <= FIN;
                            end else begin
                                group_cnt    <= group_cnt + 10'd1;
                                tile_cnt     <= '0;
                                bias_rd_en   <= 1'b1;
                                bias_rd_addr <= base_q + bias_addr_width'(group_cnt)
                                                + bias_addr_width'(1);
                                state        <= FETCH;
                            end
                        end else begin
                            tile_cnt <= tile_cnt + 8'd1;
                        end
                    end
                end
                FIN: begin
                    // done trails the final enable by one cycle.
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quan_bias_add_ctrl.sv
// tb/tb_quan_bias_add_ctrl.sv - randomized self-checking bench for quan_bias_add_ctrl
module tb_quan_bias_add_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mode;
    logic [9:0]  cfg_ch_groups;
    logic [7:0]  cfg_tiles;
    logic [9:0]  cfg_bias_base;
    logic        bias_rd_en;
    logic [9:0]  bias_rd_addr;
    logic [15:0] bias_rd_data = '0;
    logic        sum_valid;
    logic        sum_ready;
    logic [15:0] next_bias_set;
    logic        en_pre;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:1023];

    // observations of one pass
    logic [9:0]  rd_addrs[$];
    logic [15:0] en_sets[$];
    int          en_cycles[$];
    int          done_cycles[$];
    int          gaps[$];
    int          err_count;
    int          align_err;
    int          first_ready;
    bit          busy_seen;
    bit          timed_out;
    bit          rst_zero_ok;

    // reference model results
    logic [9:0]  exp_addrs[$];
    logic [15:0] exp_sets[$];

    quan_bias_add_ctrl dut (
        .clk                          (clk),
        .reset                        (reset),
        .start                        (start),
        .mode                         (mode),
        .cfg_ch_groups                (cfg_ch_groups),
        .cfg_tiles                    (cfg_tiles),
        .cfg_bias_base                (cfg_bias_base),
        .bias_rd_en                   (bias_rd_en),
        .bias_rd_addr                 (bias_rd_addr),
        .bias_rd_data                 (bias_rd_data),
        .sum_valid                    (sum_valid),
        .sum_ready                    (sum_ready),
        .next_bias_set                (next_bias_set),
        .core_product_add_bias_en_pre (en_pre),
        .busy                         (busy),
        .done                         (done),
        .cfg_err                      (cfg_err)
    );

    always #5 clk = ~clk;

    // bias buffer: data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (bias_rd_en) bias_rd_data <= mem[bias_rd_addr];
    end

    function automatic logic drive_valid(input int pat, input int c);
        case (pat)
            0:       return 1'b1;
            1:       return (c % 2) == 0;
            default: return 1'($urandom % 2);
        endcase
    endfunction

    // One read per group at base+group (mod 1024); every tile of a group sees that group's set.
    function automatic void build_model(input logic m, input logic [9:0] g,
                                        input logic [7:0] t, input logic [9:0] b);
        exp_addrs.delete();
        exp_sets.delete();
        for (int gi = 0; gi < int'(g); gi++) begin
            logic [9:0]  a;
            logic [15:0] w;
            a = 10'((int'(b) + gi) % 1024);
            w = mem[a];
            exp_addrs.push_back(a);
            for (int ti = 0; ti < int'(t); ti++) exp_sets.push_back(m ? w : {8'h00, w[7:0]});
        end
    endfunction

    task automatic run_pass(input logic [3:0] m, input logic [9:0] g, input logic [7:0] t,
                            input logic [9:0] b, input int pat, input int rst_at, input bit stray);
        logic exp_en;
        int   end_c;
        int   gap;
        bit   seen_ready;
        rd_addrs.delete(); en_sets.delete(); en_cycles.delete(); done_cycles.delete(); gaps.delete();
        err_count = 0; align_err = 0; first_ready = -1; busy_seen = 0; rst_zero_ok = 1; timed_out = 1;
        exp_en = 1'b0; end_c = -1; gap = 0; seen_ready = 0;
        @(negedge clk);
        start = 1'b1; mode = m; cfg_ch_groups = g; cfg_tiles = t; cfg_bias_base = b;
        sum_valid = drive_valid(pat, 0);
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (en_pre !== exp_en) align_err++;
            if (bias_rd_en) rd_addrs.push_back(bias_rd_addr);
            if (en_pre) begin en_sets.push_back(next_bias_set); en_cycles.push_back(c); end
            if (done) begin done_cycles.push_back(c); if (end_c < 0) end_c = c + 2; end
            if (cfg_err) begin err_count++; if (end_c < 0) end_c = c + 2; end
            if (busy) busy_seen = 1;
            if (sum_ready && first_ready < 0) first_ready = c;
            if (sum_ready) begin
                if (gap > 0) gaps.push_back(gap);
                gap = 0; seen_ready = 1;
            end else if (seen_ready) begin
                gap++;
            end
            if (rst_at >= 0 && c == rst_at + 1) begin
                if ({bias_rd_en, bias_rd_addr, next_bias_set, en_pre, busy, done, cfg_err, sum_ready} !== '0)
                    rst_zero_ok = 0;
            end
            reset = (c == rst_at);
            start = stray && (c == 4);
            if (c == 1 || c == 4) begin
                mode = 4'($urandom); cfg_ch_groups = 10'($urandom);
                cfg_tiles = 8'($urandom); cfg_bias_base = 10'($urandom);
            end
            sum_valid = drive_valid(pat, c);
            exp_en = sum_valid && sum_ready && !reset;
            if (rst_at >= 0 && c == rst_at) end_c = rst_at + 4;
            if (c == end_c) begin timed_out = 0; break; end
        end
        start = 1'b0; sum_valid = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bias_rd_en, bias_rd_addr, next_bias_set, en_pre, busy, done, cfg_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0",
                     {bias_rd_en, bias_rd_addr, next_bias_set, en_pre, busy, done, cfg_err});
        end
        checks++;
        if (sum_ready !== 1'b0) begin failures++; $display("FAIL reset_sum_ready got=%0b exp=0", sum_ready); end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        mem[10'h010] = 16'hA5F3;
        mem[10'h011] = 16'h7E81;
        run_pass(4'd1, 10'd2, 8'd3, 10'h010, 0, -1, 1'b1);
        checks++;
        if (timed_out) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
        checks++;
        if (rd_addrs.size() != 2) begin failures++; $display("FAIL basic_reads got=%0d exp=2", rd_addrs.size()); end
        else begin
            checks++;
            if (rd_addrs[0] !== 10'h010 || rd_addrs[1] !== 10'h011) begin
                failures++; $display("FAIL basic_addr got=%0h,%0h exp=10,11", rd_addrs[0], rd_addrs[1]);
            end
        end
        checks++;
        if (en_sets.size() != 6) begin failures++; $display("FAIL basic_en_count got=%0d exp=6", en_sets.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (en_sets[i] !== (i < 3 ? 16'hA5F3 : 16'h7E81)) begin
                    failures++; $display("FAIL basic_bias_set[%0d] got=%0h exp=%0h", i, en_sets[i],
                                         (i < 3 ? 16'hA5F3 : 16'h7E81));
                end
            end
        end
        checks++;
        if (done_cycles.size() != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cycles.size()); end
        else if (en_cycles.size() > 0) begin
            checks++;
            if (done_cycles[0] != en_cycles[$] + 1) begin
                failures++; $display("FAIL basic_done_timing got=%0d exp=%0d", done_cycles[0], en_cycles[$] + 1);
            end
        end
        checks++;
        if (first_ready != 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", first_ready); end
        checks++;
        if (gaps.size() != 1 || (gaps.size() == 1 && gaps[0] != 2)) begin
            failures++; $display("FAIL basic_group_gap got=%0d gaps first=%0d exp=1 gap of 2",
                                 gaps.size(), gaps.size() > 0 ? gaps[0] : -1);
        end
        checks++;
        if (align_err != 0) begin failures++; $display("FAIL basic_en_align got=%0d exp=0", align_err); end
    endtask

    task automatic test_mode0;
        mem[10'h2A5] = 16'hCC80;
        run_pass(4'd0, 10'd1, 8'd2, 10'h2A5, 0, -1, 1'b0);
        checks++;
        if (en_sets.size() != 2) begin failures++; $display("FAIL mode0_en_count got=%0d exp=2", en_sets.size()); end
        else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (en_sets[i] !== 16'h0080) begin failures++; $display("FAIL mode0_bias_set got=%0h exp=0080", en_sets[i]); end
            end
        end
        checks++;
        if (done_cycles.size() != 1 || rd_addrs.size() != 1) begin
            failures++; $display("FAIL mode0_done_reads got=%0d/%0d exp=1/1", done_cycles.size(), rd_addrs.size());
        end
    endtask

    task automatic test_toggle;
        mem[10'h044] = 16'h1234;
        run_pass(4'd1, 10'd1, 8'd4, 10'h044, 1, -1, 1'b0);
        checks++;
        if (en_sets.size() != 4) begin failures++; $display("FAIL toggle_en_count got=%0d exp=4", en_sets.size()); end
        checks++;
        if (align_err != 0) begin failures++; $display("FAIL toggle_en_align got=%0d exp=0", align_err); end
        checks++;
        if (done_cycles.size() != 1) begin failures++; $display("FAIL toggle_done got=%0d exp=1", done_cycles.size()); end
    endtask

    task automatic test_cfg_err;
        logic [3:0] bad_modes[2];
        bad_modes[0] = 4'd2;
        bad_modes[1] = 4'd15;
        for (int k = 0; k < 2; k++) begin
            run_pass(bad_modes[k], 10'd2, 8'd2, 10'h100, 0, -1, 1'b0);
            checks++;
            if (err_count != 1) begin failures++; $display("FAIL cfg_err_pulse got=%0d exp=1", err_count); end
            checks++;
            if (busy_seen || rd_addrs.size() != 0 || done_cycles.size() != 0 || en_sets.size() != 0) begin
                failures++; $display("FAIL cfg_err_quiet got busy=%0b reads=%0d done=%0d en=%0d exp=0/0/0/0",
                                     busy_seen, rd_addrs.size(), done_cycles.size(), en_sets.size());
            end
        end
        run_pass(4'd1, 10'd3, 8'd0, 10'h100, 0, -1, 1'b0);
        checks++;
        if (done_cycles.size() != 1 || rd_addrs.size() != 0 || err_count != 0) begin
            failures++; $display("FAIL zero_tiles got done=%0d reads=%0d err=%0d exp=1/0/0",
                                 done_cycles.size(), rd_addrs.size(), err_count);
        end
        run_pass(4'd0, 10'd0, 8'd5, 10'h100, 0, -1, 1'b0);
        checks++;
        if (done_cycles.size() != 1 || rd_addrs.size() != 0 || en_sets.size() != 0) begin
            failures++; $display("FAIL zero_groups got done=%0d reads=%0d en=%0d exp=1/0/0",
                                 done_cycles.size(), rd_addrs.size(), en_sets.size());
        end
    endtask

    task automatic test_wrap;
        run_pass(4'd1, 10'd2, 8'd1, 10'h3FF, 2, -1, 1'b0);
        checks++;
        if (rd_addrs.size() != 2 || (rd_addrs.size() == 2 && (rd_addrs[0] !== 10'h3FF || rd_addrs[1] !== 10'h000))) begin
            failures++; $display("FAIL wrap_addr got n=%0d last=%0h exp=2 reads 3ff,000",
                                 rd_addrs.size(), rd_addrs.size() > 0 ? rd_addrs[$] : 10'h0);
        end
    endtask

    task automatic test_reset_mid;
        run_pass(4'd1, 10'd2, 8'd3, 10'h020, 0, 9, 1'b0);
        checks++;
        if (!rst_zero_ok) begin failures++; $display("FAIL reset_mid_outputs got=nonzero exp=0"); end
        checks++;
        if (done_cycles.size() != 0) begin failures++; $display("FAIL reset_mid_done got=%0d exp=0", done_cycles.size()); end
        checks++;
        if (align_err != 0) begin failures++; $display("FAIL reset_mid_en_align got=%0d exp=0", align_err); end
        build_model(1'b1, 10'd2, 8'd2, 10'h020);
        run_pass(4'd1, 10'd2, 8'd2, 10'h020, 0, -1, 1'b0);
        checks++;
        if (en_sets != exp_sets || rd_addrs != exp_addrs || done_cycles.size() != 1) begin
            failures++; $display("FAIL reset_mid_restart got en=%0d reads=%0d done=%0d exp=%0d/%0d/1",
                                 en_sets.size(), rd_addrs.size(), done_cycles.size(), exp_sets.size(), exp_addrs.size());
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 10; it++) begin
            logic       m;
            logic [9:0] g;
            logic [7:0] t;
            logic [9:0] b;
            m = 1'($urandom);
            g = 10'($urandom_range(1, 3));
            t = 8'($urandom_range(1, 4));
            b = 10'($urandom);
            for (int k = 0; k < 4; k++) mem[10'(int'(b) + k)] = 16'($urandom);
            build_model(m, g, t, b);
            run_pass({3'b000, m}, g, t, b, int'($urandom_range(0, 2)), -1, 1'b1);
            checks++;
            if (timed_out) begin failures++; $display("FAIL rand%0d_timeout got=1 exp=0", it); end
            checks++;
            if (rd_addrs != exp_addrs) begin
                failures++; $display("FAIL rand%0d_reads got n=%0d exp n=%0d", it, rd_addrs.size(), exp_addrs.size());
            end
            checks++;
            if (en_sets.size() != exp_sets.size()) begin
                failures++; $display("FAIL rand%0d_en_count got=%0d exp=%0d", it, en_sets.size(), exp_sets.size());
            end else begin
                for (int i = 0; i < en_sets.size(); i++) begin
                    checks++;
                    if (en_sets[i] !== exp_sets[i]) begin
                        failures++; $display("FAIL rand%0d_bias_set[%0d] got=%0h exp=%0h", it, i, en_sets[i], exp_sets[i]);
                    end
                end
            end
            checks++;
            if (done_cycles.size() != 1 || en_cycles.size() == 0 ||
                (done_cycles.size() == 1 && en_cycles.size() > 0 && done_cycles[0] != en_cycles[$] + 1)) begin
                failures++; $display("FAIL rand%0d_done got n=%0d exp 1 pulse after last en_pre", it, done_cycles.size());
            end
            checks++;
            if (first_ready != 3) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=3", it, first_ready); end
            checks++;
            if (gaps.size() != int'(g) - 1) begin
                failures++; $display("FAIL rand%0d_gap_count got=%0d exp=%0d", it, gaps.size(), int'(g) - 1);
            end else begin
                foreach (gaps[i]) begin
                    checks++;
                    if (gaps[i] != 2) begin failures++; $display("FAIL rand%0d_gap got=%0d exp=2", it, gaps[i]); end
                end
            end
            checks++;
            if (align_err != 0 || err_count != 0) begin
                failures++; $display("FAIL rand%0d_en_align got align=%0d err=%0d exp=0/0", it, align_err, err_count);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sum_valid = 1'b0; mode = '0;
        cfg_ch_groups = '0; cfg_tiles = '0; cfg_bias_base = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        test_reset;
        test_basic;
        test_mode0;
        test_toggle;
        test_cfg_err;
        test_wrap;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
